seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Parametrised multiplexed seven-segment driver for the board's digit array. It accepts a binary value through a load/busy handshake and converts it to BCD sequentially (shift-add-3, one bit per cycle). It then scans the result right-aligned across `NUM_DIGITS` digits, with per-digit decimal points, per-digit blinking, optional leading-zero suppression and an overflow indication. It sits between the menu/countdown control logic and the board pins, and supersedes the fixed 8-digit, 3-digit-BCD display driver.

## Interface
- `NUM_DIGITS`, 8: number of digits, 2..8, even. Index 0 is the leftmost digit.
- `BIN_W`, 10: width of `value`, 4..27.
- `SCAN_DIV`, 30: `clk_out` cycles each digit stays selected, ≥1.
- `BLINK_FRAMES`, 64: number of complete scan frames per blink half-period, ≥1.
- `clk_out`  in  1  scan/system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `load`  in  1  request to convert and display `value`. Sampled only when `busy`=0.
- `value`  in  BIN_W  unsigned binary value to display.
- `busy`  out  1  conversion in progress.
- `dp_mask`  in  NUM_DIGITS  bit i lights the decimal point of digit i.
- `blink_mask`  in  NUM_DIGITS  bit i makes digit i blink (whole digit, including the dp).
- `lz_suppress`  in  1  blank leading zeros.
- `tub_sel`  out  NUM_DIGITS  one-hot digit select, active-high.
- `tub_control1`  out  8  segment code for the left half, digits 0..NUM_DIGITS/2-1.
- `tub_control2`  out  8  segment code for the right half, digits NUM_DIGITS/2..NUM_DIGITS-1.

## Operation
**Segment encoding**
- Active-high, bit0=a … bit6=g, bit7=dp.
- Digit codes 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- Dash: 40. Blank: 00.

**Converter FSM: IDLE -> SHIFT -> IDLE**
- IDLE: `busy`=0. `load`=1 captures `value` into the shift register, clears the BCD work register (NUM_DIGITS nibbles plus a carry/overflow flag), and goes to SHIFT.
- SHIFT: `busy`=1 for exactly BIN_W cycles. Each cycle:
  - add 3 to every work nibble ≥5;
  - shift left by one, moving the next MSB of the captured value into nibble 0 bit 0;
  - any bit shifted out of the top nibble sets `ovf_work`.
- On the last SHIFT cycle, the display register and `ovf` are updated atomically, and the FSM returns to IDLE.
- `load` while `busy`=1 is ignored. No queueing.
- The display register changes only at conversion completion, so scanning never shows a partial result.

**Digit formation for digit i** (BCD nibble k = NUM_DIGITS-1-i, right-aligned)
- `ovf`=1: dash on all digits.
- Otherwise, if `lz_suppress`=1, every nibble above the highest nonzero nibble is blank. Nibble 0 is never suppressed, so the value 0 shows "0".
- Bit7 = `dp_mask[i]`, OR-ed in whether or not the digit is suppressed.
- If `blink_mask[i]`=1 and the blink phase is 1, the whole code is 00.
- A nibble >9 cannot occur. If it does, the digit shows blank.

**Scan**
- The prescaler counts 0..SCAN_DIV-1. On wrap, `idx` advances, going from NUM_DIGITS-1 back to 0.
- `tub_sel` = one-hot(`idx`).
- The active half's control output carries the code of digit `idx`; the other half's control output is 00.

**Blink**
- The frame counter increments each time `idx` wraps to 0.
- The blink phase toggles when the frame counter reaches BLINK_FRAMES-1, and the counter clears at the same time.

## Timing
**Reset values**
- Prescaler, `idx`, frame counter and blink phase: 0.
- FSM: IDLE; `busy`=0.
- Display register: 0; `ovf`=0.
- `tub_sel`: bit 0 only.
- Control outputs: combinational from reset state. With `lz_suppress`=1, `blink_mask`[0]=0 and `dp_mask`[0]=0, `tub_control1`=00.

**Latency**
- `load` sampled at edge N -> `busy`=1 after edge N.
- New digits visible after edge N+BIN_W; `busy`=0 from the same edge.
- Back-to-back: `load` held high re-captures at the first IDLE edge, so one conversion completes every BIN_W+1 cycles.

**Other rules**
- Reset asserted mid-conversion aborts it immediately; the display returns to 0.
- `dp_mask`, `blink_mask` and `lz_suppress` are combinational to the outputs, with no latency.
- Digit dwell is exactly SCAN_DIV cycles; a frame is NUM_DIGITS×SCAN_DIV cycles.
- A blink half-period is BLINK_FRAMES×NUM_DIGITS×SCAN_DIV cycles.
- Simultaneous conversion completion and digit advance: the newly selected digit shows the new value.

## Test plan
1. **Reset and scan.** Reset, then 8×30 cycles with defaults -> `tub_sel` steps 01,02,…,80, each for exactly 30 cycles, then returns to 01; `busy`=0.
2. **Conversion.** `load`=1 with `value`=409 for one cycle.
   - `busy`=1 for 10 cycles; no display change during that time.
   - Then, with `lz_suppress`=1, digits 5..7 show 66,3F,6F; digits 0..4 show 00.
3. **Leading zeros and dp.** `value`=0, `lz_suppress`=1, `dp_mask`=0x01.
   - Digit 7 shows 3F; digit 0 shows 80; all others show 00.
   - With `lz_suppress`=0, every digit shows 3F, except digit 0, which shows BF.
4. **Overflow and busy.**
   - NUM_DIGITS=2, BIN_W=8, `value`=123 -> both digits show 40.
   - `value`=99 -> digits show 6F,6F.
   - `load` pulsed again while `busy`=1 -> ignored; the result still reflects the first value.
5. **Blink.** BLINK_FRAMES=2, `blink_mask`=0x80 -> digit 7 shows 00 during alternate 2-frame windows; the other digits are unaffected.
6. **Reset mid-conversion.** Reset at cycle 5 of a conversion -> `busy`=0 immediately, display value 0, `tub_sel`=01.

Source files
------------

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment driver: a binary value is converted to BCD one bit per
// cycle (shift-add-3), then scanned right-aligned across NUM_DIGITS digits.
module seg_display_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int BIN_W        = 10,
  parameter int SCAN_DIV     = 30,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk_out,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  output logic                  busy,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  lz_suppress,
  output logic [NUM_DIGITS-1:0] tub_sel,
  output logic [7:0]            tub_control1,
  output logic [7:0]            tub_control2
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CNT_W = $clog2(BIN_W);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(NUM_DIGITS / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] w);
    logic [BCD_W-1:0] r;
    r = w;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w[4*k +: 4] >= 4'd5) r[4*k +: 4] = w[4*k +: 4] + 4'd3;
      else                     r[4*k +: 4] = w[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'h3F;
      4'd1:    c = 8'h06;
      4'd2:    c = 8'h5B;
      4'd3:    c = 8'h4F;
      4'd4:    c = 8'h66;
      4'd5:    c = 8'h6D;
      4'd6:    c = 8'h7D;
      4'd7:    c = 8'h07;
      4'd8:    c = 8'h7F;
      4'd9:    c = 8'h6F;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   work_q;
  logic               ovf_work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   disp_q;
  logic               ovf_q;
  logic [PRE_W-1:0]   pre_q;
  logic [IDX_W-1:0]   idx_q;
  logic [FRM_W-1:0]   frm_q;
  logic               phase_q;

  logic [BCD_W-1:0]   adj_s;
  logic [BCD_W-1:0]   step_s;
  logic               carry_s;
  logic               last_s;
  logic               pre_wrap_s;
  logic               idx_wrap_s;
  logic               any_nz_s;
  logic [NUM_DIGITS-1:0] sup_s;
  logic [IDX_W-1:0]   nib_idx_s;
  logic [3:0]         nib_s;
  logic               sup_sel_s;
  logic [7:0]         code_s;

  // Converter state register
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Converter next state: one SHIFT cycle per input bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_SHIFT;
        else      state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        else                   state_d = ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Converter outputs
  always_comb begin
    busy = 1'b0;
    case (state_q)
      ST_SHIFT: busy = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // One double-dabble step; the bit leaving the top nibble flags overflow
  always_comb begin
    adj_s              = add3_all(work_q);
    {carry_s, step_s}  = {adj_s, shift_q[BIN_W-1]};
    last_s             = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  end

  // Conversion datapath; the display register only changes on the final step
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      cnt_q      <= '0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            shift_q    <= value;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        ST_SHIFT: begin
          shift_q    <= shift_q << 1;
          work_q     <= step_s;
          ovf_work_q <= ovf_work_q | carry_s;
          cnt_q      <= cnt_q + CNT_W'(1);
          if (last_s) begin
            disp_q <= step_s;
            ovf_q  <= ovf_work_q | carry_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign pre_wrap_s = (pre_q == PRE_LAST);
  assign idx_wrap_s = pre_wrap_s && (idx_q == IDX_LAST);

  // Scan prescaler, digit index, frame counter and blink phase
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (pre_wrap_s) pre_q <= '0;
      else            pre_q <= pre_q + PRE_W'(1);
      if (pre_wrap_s) begin
        if (idx_wrap_s) idx_q <= '0;
        else            idx_q <= idx_q + IDX_W'(1);
      end
      if (idx_wrap_s) begin
        if (frm_q == FRM_LAST) begin
          frm_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          frm_q <= frm_q + FRM_W'(1);
        end
      end
    end
  end

  // Leading-zero map: a nibble is blank while everything above it is zero
  always_comb begin
    any_nz_s = 1'b0;
    sup_s    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (disp_q[4*k +: 4] != 4'd0) any_nz_s = 1'b1;
      else                          any_nz_s = any_nz_s;
      sup_s[k] = lz_suppress && !any_nz_s && (k != 0);
    end
  end

  // Code of the selected digit (digit i shows nibble NUM_DIGITS-1-i)
  always_comb begin
    nib_idx_s = IDX_LAST - idx_q;
    nib_s     = 4'd0;
    sup_sel_s = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == nib_idx_s) begin
        nib_s     = disp_q[4*k +: 4];
        sup_sel_s = sup_s[k];
      end else begin
        nib_s     = nib_s;
        sup_sel_s = sup_sel_s;
      end
    end
    if (ovf_q)          code_s = 8'h40;
    else if (sup_sel_s) code_s = 8'h00;
    else                code_s = seg7(nib_s);
    code_s[7] = dp_mask[idx_q];
    if (blink_mask[idx_q] && phase_q) code_s = 8'h00;
    else                              code_s = code_s;
  end

  // Digit select and half-bank routing
  always_comb begin
    tub_sel        = '0;
    tub_sel[idx_q] = 1'b1;
    if (idx_q < IDX_HALF) begin
      tub_control1 = code_s;
      tub_control2 = 8'h00;
    end else begin
      tub_control1 = 8'h00;
      tub_control2 = code_s;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: two instances (8-digit and 2-digit) compared every cycle
// against an arithmetic model of the displayed number, scan position and blink phase.
module tb_seg_display_scan;

  localparam int AN = 8, AW = 10, AS = 30, AB = 2;
  localparam int BN = 2, BW = 8,  BS = 3,  BB = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic          a_load = 1'b0;
  logic [AW-1:0] a_value = '0;
  logic [AN-1:0] a_dp = '0, a_blink = '0;
  logic          a_lz = 1'b0;
  logic          a_busy;
  logic [AN-1:0] a_sel;
  logic [7:0]    a_c1, a_c2;

  logic          b_load = 1'b0;
  logic [BW-1:0] b_value = '0;
  logic [BN-1:0] b_dp = '0, b_blink = '0;
  logic          b_lz = 1'b0;
  logic          b_busy;
  logic [BN-1:0] b_sel;
  logic [7:0]    b_c1, b_c2;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  t = 0;
  int  a_disp = 0, a_pend = 0, a_rem = 0;
  bit  a_busy_m = 1'b0;
  int  b_disp = 0, b_pend = 0, b_rem = 0;
  bit  b_busy_m = 1'b0;

  seg_display_scan #(.NUM_DIGITS(AN), .BIN_W(AW), .SCAN_DIV(AS), .BLINK_FRAMES(AB)) u_dut_a (
    .clk_out(clk), .reset(reset), .load(a_load), .value(a_value), .busy(a_busy),
    .dp_mask(a_dp), .blink_mask(a_blink), .lz_suppress(a_lz),
    .tub_sel(a_sel), .tub_control1(a_c1), .tub_control2(a_c2)
  );

  seg_display_scan #(.NUM_DIGITS(BN), .BIN_W(BW), .SCAN_DIV(BS), .BLINK_FRAMES(BB)) u_dut_b (
    .clk_out(clk), .reset(reset), .load(b_load), .value(b_value), .busy(b_busy),
    .dp_mask(b_dp), .blink_mask(b_blink), .lz_suppress(b_lz),
    .tub_sel(b_sel), .tub_control1(b_c1), .tub_control2(b_c2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic longint pow10(input int k);
    longint r;
    r = 1;
    for (int j = 0; j < k; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    return tbl[d];
  endfunction

  // Expected code of digit i when the display holds decimal number val
  function automatic logic [7:0] exp_code(input int n, input int val, input int i,
                                          input bit dp, input bit bl, input bit lz, input bit ph);
    logic [7:0] c;
    int k;
    k = n - 1 - i;
    if (longint'(val) >= pow10(n))               c = 8'h40;
    else if (lz && k > 0 && longint'(val) < pow10(k)) c = 8'h00;
    else c = seg_of(int'((longint'(val) / pow10(k)) % 10));
    if (dp) c[7] = 1'b1;
    if (bl && ph) c = 8'h00;
    return c;
  endfunction

  task automatic check_all();
    int ia, ib;
    bit pa, pb;
    logic [7:0] ca, cb;
    ia = (t / AS) % AN;
    pa = ((t / (AS * AN * AB)) % 2) == 1;
    ca = exp_code(AN, a_disp, ia, a_dp[ia], a_blink[ia], a_lz, pa);
    check_eq("a_sel",  32'(a_sel), 32'(1) << ia);
    check_eq("a_ctl1", 32'(a_c1), (ia < AN / 2) ? 32'(ca) : 32'd0);
    check_eq("a_ctl2", 32'(a_c2), (ia < AN / 2) ? 32'd0 : 32'(ca));
    check_eq("a_busy", 32'(a_busy), 32'(a_busy_m));
    ib = (t / BS) % BN;
    pb = ((t / (BS * BN * BB)) % 2) == 1;
    cb = exp_code(BN, b_disp, ib, b_dp[ib], b_blink[ib], b_lz, pb);
    check_eq("b_sel",  32'(b_sel), 32'(1) << ib);
    check_eq("b_ctl1", 32'(b_c1), (ib < BN / 2) ? 32'(cb) : 32'd0);
    check_eq("b_ctl2", 32'(b_c2), (ib < BN / 2) ? 32'd0 : 32'(cb));
    check_eq("b_busy", 32'(b_busy), 32'(b_busy_m));
  endtask

  // Model sees the inputs present at the coming edge, then outputs are checked after it
  task automatic tick();
    if (a_busy_m) begin
      a_rem--;
      if (a_rem == 0) begin a_busy_m = 1'b0; a_disp = a_pend; end
    end else if (a_load) begin
      a_busy_m = 1'b1; a_rem = AW; a_pend = int'(a_value);
    end
    if (b_busy_m) begin
      b_rem--;
      if (b_rem == 0) begin b_busy_m = 1'b0; b_disp = b_pend; end
    end else if (b_load) begin
      b_busy_m = 1'b1; b_rem = BW; b_pend = int'(b_value);
    end
    @(posedge clk);
    #1;
    t++;
    check_all();
  endtask

  task automatic do_reset();
    a_load = 1'b0;
    b_load = 1'b0;
    reset = 1'b1;
    #1;
    t = 0;
    a_disp = 0; a_busy_m = 1'b0; a_rem = 0;
    b_disp = 0; b_busy_m = 1'b0; b_rem = 0;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    a_lz = 1'b1;
    do_reset();
    a_lz = 1'b0;
    repeat (250) tick();

    a_value = AW'(409); a_lz = 1'b1; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    repeat (300) tick();

    a_value = '0; a_dp = AN'(8'h01); a_load = 1'b1;
    tick();
    a_load = 1'b0;
    repeat (AW + 250) tick();
    a_lz = 1'b0;
    repeat (250) tick();

    b_value = BW'(123); b_load = 1'b1;
    tick();
    b_load = 1'b0;
    repeat (20) tick();
    b_value = BW'(99); b_load = 1'b1;
    tick();
    b_load = 1'b0;
    repeat (3) tick();
    b_value = BW'(123); b_load = 1'b1;
    tick();
    b_load = 1'b0;
    repeat (20) tick();

    a_dp = '0; a_blink = AN'(8'h80); b_blink = BN'(2'b10);
    repeat (1200) tick();

    a_blink = '0;
    a_value = AW'(1000); a_load = 1'b1;
    tick();
    a_load = 1'b0;
    repeat (5) tick();
    do_reset();
    repeat (20) tick();

    repeat (4000) begin
      a_load  = ($urandom_range(0, 15) == 0);
      a_value = AW'($urandom_range(0, (1 << AW) - 1));
      b_load  = ($urandom_range(0, 7) == 0);
      b_value = BW'($urandom_range(0, (1 << BW) - 1));
      if ($urandom_range(0, 63) == 0) begin
        a_dp = AN'($urandom); a_blink = AN'($urandom); a_lz = 1'($urandom);
        b_dp = BN'($urandom); b_blink = BN'($urandom); b_lz = 1'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
